// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous RAM port between instruction fetch (IFU)
// and the load/store unit (LSU). Requests and responses both use valid/ready;
// a response that cannot be delivered is parked in a hold register until the
// owner takes it. Drives the RAM tracing sideband (ifetch flag and pc).
//
// Build option: define MEM_ARB_RR_EN for round-robin arbitration on ties.
// Without it, the LSU always wins over the IFU and no last-grant state exists.
`timescale 1ns/1ps

module mem_arbiter #(
    parameter int XLEN = 32
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [XLEN-1:0]     ifu_req_addr,
    output logic                ifu_rsp_valid,
    input  logic                ifu_rsp_ready,
    output logic [XLEN-1:0]     ifu_rsp_rdata,

    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic                lsu_req_write,
    input  logic [XLEN-1:0]     lsu_req_addr,
    input  logic [XLEN/8-1:0]   lsu_req_strobe,
    input  logic [XLEN-1:0]     lsu_req_wdata,
    input  logic [XLEN-1:0]     lsu_req_pc,
    output logic                lsu_rsp_valid,
    input  logic                lsu_rsp_ready,
    output logic [XLEN-1:0]     lsu_rsp_rdata,

    output logic                mem_valid,
    output logic                mem_write,
    output logic [XLEN-1:0]     mem_addr,
    output logic [XLEN/8-1:0]   mem_strobe,
    output logic [XLEN-1:0]     mem_wdata,
    output logic                mem_ifetch,
    output logic [XLEN-1:0]     mem_pc,
    input  logic [XLEN-1:0]     mem_rdata
);

    // Handshake rule on every channel: a transfer happens on the rising clock
    // edge where valid and ready are both 1. A requester keeps valid and its
    // fields stable until it sees ready; req_ready is combinational, so the
    // grant and the RAM access happen in the same cycle as the acceptance.

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // nothing outstanding
        ST_BUSY = 2'd1,   // access issued last cycle, RAM data on mem_rdata now
        ST_HOLD = 2'd2    // response captured, waiting for owner's rsp_ready
    } state_t;

    localparam logic OWN_IFU = 1'b0;
    localparam logic OWN_LSU = 1'b1;

    state_t             state_q;
    logic               owner_q;     // requester that owns the outstanding response
    logic               wr_q;        // outstanding access is a store (ack carries 0)
    logic [XLEN-1:0]    hold_q;      // parked response data

    logic               owner_rsp_ready;
    logic               issue_ok;
    logic               grant_ifu;
    logic               grant_lsu;
    logic               grant_any;
    logic [XLEN-1:0]    hold_d;      // response data as seen in BUSY
    logic [XLEN-1:0]    rsp_data;
    logic               rsp_active;

`ifdef MEM_ARB_RR_EN
    logic               last_grant_q;
`endif

    // Issue permission: idle, or the current response completes this cycle.
    // Reset forces every ready and mem_valid low even while rst is held.
    always_comb begin
        owner_rsp_ready = (owner_q == OWN_LSU) ? lsu_rsp_ready : ifu_rsp_ready;
        issue_ok        = ~rst & ((state_q == ST_IDLE) |
                                  ((state_q == ST_BUSY) & owner_rsp_ready));
    end

    // Arbitration between the two requesters.
    always_comb begin
`ifdef MEM_ARB_RR_EN
        // On a tie, the requester that did not win last time is granted.
        grant_ifu = issue_ok & ifu_req_valid &
                    (~lsu_req_valid | (last_grant_q == OWN_LSU));
        grant_lsu = issue_ok & lsu_req_valid &
                    (~ifu_req_valid | (last_grant_q == OWN_IFU));
`else
        // Fixed priority: the LSU always wins a tie.
        grant_lsu = issue_ok & lsu_req_valid;
        grant_ifu = issue_ok & ifu_req_valid & ~lsu_req_valid;
`endif
        grant_any = grant_ifu | grant_lsu;
    end

    assign ifu_req_ready = grant_ifu;
    assign lsu_req_ready = grant_lsu;

    // RAM request fields come straight from the winner; zeros when idle.
    always_comb begin
        mem_valid  = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = '0;
        mem_strobe = '0;
        mem_wdata  = '0;
        mem_ifetch = 1'b0;
        mem_pc     = '0;
        if (grant_lsu) begin
            mem_valid  = 1'b1;
            mem_write  = lsu_req_write;
            mem_addr   = lsu_req_addr;
            mem_strobe = lsu_req_strobe;
            mem_wdata  = lsu_req_wdata;
            mem_ifetch = 1'b0;
            mem_pc     = lsu_req_pc;
        end else if (grant_ifu) begin
            mem_valid  = 1'b1;
            mem_write  = 1'b0;
            mem_addr   = ifu_req_addr;
            mem_strobe = '1;
            mem_wdata  = '0;
            mem_ifetch = 1'b1;
            mem_pc     = ifu_req_addr;
        end
    end

    // Response path: live RAM data in BUSY, parked data in HOLD; stores ack with 0.
    always_comb begin
        hold_d     = wr_q ? '0 : mem_rdata;
        rsp_data   = (state_q == ST_HOLD) ? hold_q : hold_d;
        rsp_active = (state_q == ST_BUSY) | (state_q == ST_HOLD);

        ifu_rsp_valid = rsp_active & (owner_q == OWN_IFU);
        lsu_rsp_valid = rsp_active & (owner_q == OWN_LSU);
        ifu_rsp_rdata = ifu_rsp_valid ? rsp_data : '0;
        lsu_rsp_rdata = lsu_rsp_valid ? rsp_data : '0;
    end

    // Main FSM: tracks the outstanding access, its owner and the hold register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            owner_q <= OWN_IFU;
            wr_q    <= 1'b0;
            hold_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grant_any) begin
                        state_q <= ST_BUSY;
                        owner_q <= grant_lsu ? OWN_LSU : OWN_IFU;
                        wr_q    <= grant_lsu & lsu_req_write;
                    end
                end
                ST_BUSY: begin
                    if (owner_rsp_ready) begin
                        // Response delivered; a new grant keeps the port busy
                        // for back-to-back accesses.
                        if (grant_any) begin
                            state_q <= ST_BUSY;
                            owner_q <= grant_lsu ? OWN_LSU : OWN_IFU;
                            wr_q    <= grant_lsu & lsu_req_write;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        // Owner stalled: RAM data is only valid now, so park it.
                        hold_q  <= hold_d;
                        state_q <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (owner_rsp_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef MEM_ARB_RR_EN
    // Remember who won the most recent grant for tie-breaking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= OWN_LSU;
        end else if (grant_any) begin
            last_grant_q <= grant_lsu ? OWN_LSU : OWN_IFU;
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter with a small synchronous RAM model,
// an expected-response scoreboard and a negedge monitor.
`timescale 1ns/1ps

module tb_mem_arbiter;

    localparam int XLEN = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;

    logic              ifu_req_valid = 1'b0;
    logic              ifu_req_ready;
    logic [XLEN-1:0]   ifu_req_addr = '0;
    logic              ifu_rsp_valid;
    logic              ifu_rsp_ready = 1'b1;
    logic [XLEN-1:0]   ifu_rsp_rdata;

    logic              lsu_req_valid = 1'b0;
    logic              lsu_req_ready;
    logic              lsu_req_write = 1'b0;
    logic [XLEN-1:0]   lsu_req_addr = '0;
    logic [3:0]        lsu_req_strobe = '0;
    logic [XLEN-1:0]   lsu_req_wdata = '0;
    logic [XLEN-1:0]   lsu_req_pc = '0;
    logic              lsu_rsp_valid;
    logic              lsu_rsp_ready = 1'b1;
    logic [XLEN-1:0]   lsu_rsp_rdata;

    logic              mem_valid;
    logic              mem_write;
    logic [XLEN-1:0]   mem_addr;
    logic [3:0]        mem_strobe;
    logic [XLEN-1:0]   mem_wdata;
    logic              mem_ifetch;
    logic [XLEN-1:0]   mem_pc;
    logic [XLEN-1:0]   mem_rdata = '0;

    mem_arbiter #(.XLEN(XLEN)) dut (
        .clk            (clk),
        .rst            (rst),
        .ifu_req_valid  (ifu_req_valid),
        .ifu_req_ready  (ifu_req_ready),
        .ifu_req_addr   (ifu_req_addr),
        .ifu_rsp_valid  (ifu_rsp_valid),
        .ifu_rsp_ready  (ifu_rsp_ready),
        .ifu_rsp_rdata  (ifu_rsp_rdata),
        .lsu_req_valid  (lsu_req_valid),
        .lsu_req_ready  (lsu_req_ready),
        .lsu_req_write  (lsu_req_write),
        .lsu_req_addr   (lsu_req_addr),
        .lsu_req_strobe (lsu_req_strobe),
        .lsu_req_wdata  (lsu_req_wdata),
        .lsu_req_pc     (lsu_req_pc),
        .lsu_rsp_valid  (lsu_rsp_valid),
        .lsu_rsp_ready  (lsu_rsp_ready),
        .lsu_rsp_rdata  (lsu_rsp_rdata),
        .mem_valid      (mem_valid),
        .mem_write      (mem_write),
        .mem_addr       (mem_addr),
        .mem_strobe     (mem_strobe),
        .mem_wdata      (mem_wdata),
        .mem_ifetch     (mem_ifetch),
        .mem_pc         (mem_pc),
        .mem_rdata      (mem_rdata)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- RAM model ----------------
    // 32 words; index built from address bits so the test addresses are distinct.
    logic [31:0] ram [0:31];
    logic        pl_en = 1'b0;
    logic [31:0] pl_addr = '0;
    logic [31:0] pl_data = '0;

    function automatic logic [4:0] ram_idx(input logic [31:0] a);
        return {a[13:12], a[4:2]};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] st);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (st[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    // Reads return data the next cycle; otherwise rdata carries junk.
    always @(posedge clk) begin
        if (pl_en) ram[ram_idx(pl_addr)] <= pl_data;
        else if (mem_valid && mem_write)
            ram[ram_idx(mem_addr)] <= merge(ram[ram_idx(mem_addr)], mem_wdata, mem_strobe);
        if (mem_valid && !mem_write) mem_rdata <= ram[ram_idx(mem_addr)];
        else                         mem_rdata <= {16'hA5A5, cyc[15:0]};
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int failures = 0;

    logic [101:0] exp_mem_q[$];
    logic [31:0]  exp_ifu_q[$];
    logic [31:0]  exp_lsu_q[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [101:0] pk(input logic w, input logic f, input logic [3:0] s,
                                        input logic [31:0] a, input logic [31:0] d,
                                        input logic [31:0] p);
        return {w, f, s, a, d, p};
    endfunction

    function automatic logic [101:0] pk_ifu(input logic [31:0] a);
        return pk(1'b0, 1'b1, 4'hF, a, 32'h0, a);
    endfunction

    // Monitor: pops expectations whenever the DUT presents a RAM access or a
    // response transfer; samples on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_valid) begin
                if (exp_mem_q.size() == 0) chk("mem_unexpected", 1, 0);
                else chk("mem_access",
                         pk(mem_write, mem_ifetch, mem_strobe, mem_addr, mem_wdata, mem_pc),
                         exp_mem_q.pop_front());
            end
            if (ifu_rsp_valid && ifu_rsp_ready) begin
                if (exp_ifu_q.size() == 0) chk("ifu_rsp_unexpected", 1, 0);
                else chk("ifu_rsp_rdata", ifu_rsp_rdata, exp_ifu_q.pop_front());
            end
            if (lsu_rsp_valid && lsu_rsp_ready) begin
                if (exp_lsu_q.size() == 0) chk("lsu_rsp_unexpected", 1, 0);
                else chk("lsu_rsp_rdata", lsu_rsp_rdata, exp_lsu_q.pop_front());
            end
            chk("rsp_exclusive", ifu_rsp_valid & lsu_rsp_valid, 0);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        tick();
        pl_en = 1'b0;
    endtask

    task automatic do_lsu(input logic w, input logic [31:0] a, input logic [3:0] s,
                          input logic [31:0] d, input logic [31:0] p);
        logic got;
        got = 1'b0;
        lsu_req_valid = 1'b1; lsu_req_write = w; lsu_req_addr = a;
        lsu_req_strobe = s; lsu_req_wdata = d; lsu_req_pc = p;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (lsu_req_ready) begin got = 1'b1; break; end
        end
        if (!got) chk("lsu_req_timeout", 0, 1);
        tick();
        lsu_req_valid = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    int c0, c1;
    logic [5:0] rr_exp;

    initial begin
        // Reset and RAM preload.
        preload(32'h8000_0000, 32'h0000_0413);
        preload(32'h8000_0004, 32'h0010_0093);
        preload(32'h8000_0008, 32'h1111_2222);
        preload(32'h8000_1000, 32'hCAFE_F00D);
        preload(32'h8000_2000, 32'hAABB_CCDD);
        preload(32'h8000_3000, 32'hDEAD_BEEF);

        // Reset state: readies stay low even with requests pending.
        ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
        @(negedge clk);
        chk("rst_ifu_req_ready", ifu_req_ready, 0);
        chk("rst_lsu_req_ready", lsu_req_ready, 0);
        chk("rst_rsp_valids", {ifu_rsp_valid, lsu_rsp_valid}, 0);
        chk("rst_mem_valid", mem_valid, 0);
        chk("rst_data_outs", {mem_addr, mem_pc, ifu_rsp_rdata, lsu_rsp_rdata}, 0);
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        // 1: IFU read alone.
        exp_mem_q.push_back(pk_ifu(32'h8000_0000));
        exp_ifu_q.push_back(32'h0000_0413);
        ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0000;
        @(negedge clk);
        c0 = cyc;
        chk("t1_ifu_req_ready", ifu_req_ready, 1);
        chk("t1_mem_ifetch", mem_ifetch, 1);
        tick();
        ifu_req_valid = 1'b0;
        @(negedge clk);
        c1 = cyc;
        chk("t1_ifu_rsp_valid", ifu_rsp_valid, 1);
        chk("t1_latency", c1 - c0, 1);
        tick();
        @(negedge clk);
        chk("t1_idle_after", {ifu_rsp_valid, mem_valid}, 0);
        tick();

        // 2: simultaneous requests, LSU first, IFU next cycle with no gap.
        exp_mem_q.push_back(pk(1'b0, 1'b0, 4'hF, 32'h8000_1000, 32'h0, 32'h8000_0020));
        exp_mem_q.push_back(pk_ifu(32'h8000_0004));
        exp_lsu_q.push_back(32'hCAFE_F00D);
        exp_ifu_q.push_back(32'h0010_0093);
        ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0004;
        lsu_req_valid = 1'b1; lsu_req_write = 1'b0; lsu_req_addr = 32'h8000_1000;
        lsu_req_strobe = 4'hF; lsu_req_wdata = 32'h0; lsu_req_pc = 32'h8000_0020;
        @(negedge clk);
        chk("t2_lsu_req_ready", lsu_req_ready, 1);
        chk("t2_ifu_req_ready", ifu_req_ready, 0);
        tick();
        lsu_req_valid = 1'b0;
        @(negedge clk);
        chk("t2_ifu_req_ready_next", ifu_req_ready, 1);
        chk("t2_mem_valid_b2b", mem_valid, 1);
        chk("t2_lsu_rsp_valid", lsu_rsp_valid, 1);
        tick();
        ifu_req_valid = 1'b0;
        @(negedge clk);
        chk("t2_ifu_rsp_valid", ifu_rsp_valid, 1);
        tick();

        // 3: LSU response backpressure; IFU waits until the hold drains.
        exp_mem_q.push_back(pk(1'b0, 1'b0, 4'hF, 32'h8000_3000, 32'h0, 32'h8000_0024));
        exp_mem_q.push_back(pk_ifu(32'h8000_0008));
        exp_lsu_q.push_back(32'hDEAD_BEEF);
        exp_ifu_q.push_back(32'h1111_2222);
        lsu_rsp_ready = 1'b0;
        ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0008;
        lsu_req_valid = 1'b1; lsu_req_write = 1'b0; lsu_req_addr = 32'h8000_3000;
        lsu_req_strobe = 4'hF; lsu_req_wdata = 32'h0; lsu_req_pc = 32'h8000_0024;
        @(negedge clk);
        chk("t3_lsu_req_ready", lsu_req_ready, 1);
        chk("t3_ifu_req_ready", ifu_req_ready, 0);
        tick();
        lsu_req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t3_hold_valid", lsu_rsp_valid, 1);
            chk("t3_hold_rdata", lsu_rsp_rdata, 32'hDEAD_BEEF);
            chk("t3_hold_no_mem", mem_valid, 0);
            chk("t3_hold_ifu_wait", ifu_req_ready, 0);
            tick();
        end
        lsu_rsp_ready = 1'b1;
        @(negedge clk);
        chk("t3_drain_ifu_wait", ifu_req_ready, 0);
        chk("t3_drain_no_mem", mem_valid, 0);
        tick();
        @(negedge clk);
        chk("t3_ifu_granted", ifu_req_ready, 1);
        tick();
        ifu_req_valid = 1'b0;
        repeat (2) tick();

        // 4: partial store then read-back of the merged word.
        exp_mem_q.push_back(pk(1'b1, 1'b0, 4'h3, 32'h8000_2000, 32'h1234_5678, 32'h8000_0010));
        exp_lsu_q.push_back(32'h0);
        exp_mem_q.push_back(pk(1'b0, 1'b0, 4'hF, 32'h8000_2000, 32'h0, 32'h8000_0014));
        exp_lsu_q.push_back(32'hAABB_5678);
        do_lsu(1'b1, 32'h8000_2000, 4'h3, 32'h1234_5678, 32'h8000_0010);
        do_lsu(1'b0, 32'h8000_2000, 4'hF, 32'h0, 32'h8000_0014);
        repeat (2) tick();

        // 5: asynchronous reset while BUSY.
        exp_mem_q.push_back(pk_ifu(32'h8000_0000));
        ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0000;
        @(negedge clk);
        chk("t5_ifu_req_ready", ifu_req_ready, 1);
        tick();
        lsu_req_valid = 1'b1; lsu_req_write = 1'b0; lsu_req_addr = 32'h8000_1000;
        lsu_req_strobe = 4'hF; lsu_req_pc = 32'h8000_0028;
        #1;
        rst = 1'b1;
        #1;
        chk("t5_rst_rsp_valids", {ifu_rsp_valid, lsu_rsp_valid}, 0);
        chk("t5_rst_req_readies", {ifu_req_ready, lsu_req_ready}, 0);
        chk("t5_rst_mem_valid", mem_valid, 0);
        chk("t5_rst_rdata", ifu_rsp_rdata, 0);
        tick();
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t5_no_spurious_rsp", {ifu_rsp_valid, lsu_rsp_valid}, 0);
            tick();
        end

        // 6: both requesters continuously valid for six grants.
`ifdef MEM_ARB_RR_EN
        rr_exp = 6'b010101;   // bit k = 1 means IFU wins grant k
`else
        rr_exp = 6'b000000;
`endif
        for (int k = 0; k < 6; k++) begin
            if (rr_exp[k]) begin
                exp_mem_q.push_back(pk_ifu(32'h8000_0000));
                exp_ifu_q.push_back(32'h0000_0413);
            end else begin
                exp_mem_q.push_back(pk(1'b0, 1'b0, 4'hF, 32'h8000_1000, 32'h0, 32'h8000_0030));
                exp_lsu_q.push_back(32'hCAFE_F00D);
            end
        end
        ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0000;
        lsu_req_valid = 1'b1; lsu_req_write = 1'b0; lsu_req_addr = 32'h8000_1000;
        lsu_req_strobe = 4'hF; lsu_req_wdata = 32'h0; lsu_req_pc = 32'h8000_0030;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("t6_ifu_grant", ifu_req_ready, rr_exp[k]);
            chk("t6_lsu_grant", lsu_req_ready, !rr_exp[k]);
            chk("t6_mem_valid", mem_valid, 1);
            tick();
        end
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        repeat (3) tick();

        chk("end_mem_q_empty", exp_mem_q.size(), 0);
        chk("end_ifu_q_empty", exp_ifu_q.size(), 0);
        chk("end_lsu_q_empty", exp_lsu_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog: the run is a few hundred cycles; anything longer is a hang.
    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
